arbiter_2m_1s: RTL and testbench
================================

Name: arbiter_2m_1s

Overview:
Wishbone arbiter connecting two masters (m0, m1) to one slave (s); the counterpart of the 1-master/2-slave decoder. Grants the bus per cycle (cyc_i envelope) with round-robin fairness and holds the grant until the owner drops cyc. Includes a bus watchdog that terminates hung transfers with err. Sits between CPU/DMA masters and the slave-side decoder.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
TIMEOUT, 255, cycles of unanswered stb before watchdog err; 0 disables watchdog
TO_WIDTH, 8, watchdog counter width; must satisfy TIMEOUT < 2**TO_WIDTH

Ports:
clk_i  in  1  clock, all state on rising edge
rst_n_i  in  1  asynchronous active-low reset
mN_addr_i  in  ADDR_WIDTH  master N address (N = 0, 1)
mN_data_i  in  DATA_WIDTH  master N write data
mN_data_o  out  DATA_WIDTH  master N read data
mN_cyc_i, mN_stb_i, mN_we_i  in  1 each  master N cycle/strobe/write-enable
mN_sel_i  in  4  master N byte selects
mN_ack_o, mN_err_o, mN_rty_o  out  1 each  master N terminations
s_addr_o  out  ADDR_WIDTH  slave address
s_data_o  out  DATA_WIDTH  slave write data
s_data_i  in  DATA_WIDTH  slave read data
s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle/strobe/write-enable
s_sel_o  out  4  slave byte selects
s_ack_i, s_err_i, s_rty_i  in  1 each  slave terminations

Behaviour:
- State: IDLE, GRANT0, GRANT1 (registered); last-owner bit `last` (registered); watchdog counter `wd` (TO_WIDTH bits).
- Reset (async, rst_n_i=0): state=IDLE, last=1 (m0 wins first tie), wd=0. Outputs then: s_cyc_o=s_stb_o=s_we_o=0, s_addr_o=s_data_o=0, s_sel_o=0, all mN_ack/err/rty_o=0, mN_data_o=0.
- IDLE: all slave outputs 0. At edge: only m0_cyc_i -> GRANT0; only m1_cyc_i -> GRANT1; both -> grant master != last; none -> stay. Arbitration latency: 1 cycle from cyc assertion to s_cyc_o.
- GRANTn: s_addr/data/sel/we/cyc/stb_o driven combinationally from master n; mn_ack/err/rty_o = s_ack/err/rty_i; mn_data_o = s_data_i. Non-owner: ack/err/rty=0, data_o=0. last <= n on entry.
- Release: at edge in GRANTn with mn_cyc_i=0 -> GRANTother if other cyc_i=1 (zero-cycle handover), else IDLE. s_cyc_o follows mn_cyc_i combinationally, so the slave sees the drop in the same cycle.
- No preemption: owner keeps grant across any number of transfers while cyc high.
- Watchdog (TIMEOUT>0): in GRANTn, each cycle with mn_stb_i=1 and s_ack_i|s_err_i|s_rty_i=0 increments wd; any termination, stb low, or state change clears wd. When wd==TIMEOUT: that cycle mn_err_o=1 (overriding slave), mn_ack_o=mn_rty_o=0, s_stb_o=0; wd<=0 at edge. Grant is unaffected.
- TIMEOUT=0: wd held 0, no watchdog err.
- Slave terminations arriving in IDLE are dropped.
- Reset mid-transfer: all outputs to reset values immediately, no termination delivered.

Test Plan:
- Single m0 read: m0 cyc/stb, addr=0x100; slave acks 2 cycles later with data 0xDEADBEEF -> s_cyc_o rises 1 cycle after m0_cyc_i, m0_ack_o and m0_data_o=0xDEADBEEF in ack cycle, m1 outputs 0.
- Simultaneous request after reset: m0 and m1 cyc same cycle -> GRANT0 first; m0 drops cyc -> GRANT1 on next edge with no IDLE cycle; repeat both -> m1 then m0 (alternation).
- Burst hold: m1 holds cyc for 4 acked transfers while m0 requests -> m0 never granted until m1_cyc_i=0; m0_ack_o stays 0 throughout.
- Watchdog: TIMEOUT=4, slave never acks, m0 stb held -> m0_err_o=1 exactly in 5th stb cycle, s_stb_o=0 that cycle, wd then restarts; with TIMEOUT=0 no err after 1000 cycles.
- Reset mid-op: assert rst_n_i=0 in GRANT1 mid-stb -> s_cyc_o/s_stb_o=0 asynchronously; after release and both requesting -> m0 granted.
- Slave err/rty passthrough: s_err_i pulse in GRANT0 -> m0_err_o pulse same cycle, m1_err_o=0.

Source files
------------

// File: rtl/arbiter_2m_1s.sv
// Two-master / one-slave Wishbone arbiter with round-robin grant held for the whole cyc envelope
// and a bus watchdog that terminates unanswered strobes with err.
module arbiter_2m_1s #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int TO_WIDTH   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_sel_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_sel_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [3:0]            s_sel_o,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  localparam logic                WD_EN  = (TIMEOUT != 0);
  localparam logic [TO_WIDTH-1:0] WD_LIM = TO_WIDTH'(TIMEOUT);
  localparam logic [TO_WIDTH-1:0] WD_ONE = TO_WIDTH'(1);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic [TO_WIDTH-1:0] wd_q, wd_d;
  logic                own_stb_s;
  logic                term_s;
  logic                timeout_s;

  assign term_s    = s_ack_i | s_err_i | s_rty_i;
  assign timeout_s = WD_EN && (state_q != IDLE) && (wd_q == WD_LIM);

  // Next grant, last-owner tracking and watchdog count
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    own_stb_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? GRANT0 : GRANT1;
        end else if (m0_cyc_i) begin
          state_d = GRANT0;
        end else if (m1_cyc_i) begin
          state_d = GRANT1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0: begin
        own_stb_s = m0_stb_i;
        if (!m0_cyc_i) begin
          state_d = m1_cyc_i ? GRANT1 : IDLE;
        end else begin
          state_d = GRANT0;
        end
      end
      GRANT1: begin
        own_stb_s = m1_stb_i;
        if (!m1_cyc_i) begin
          state_d = m0_cyc_i ? GRANT0 : IDLE;
        end else begin
          state_d = GRANT1;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == GRANT0) && (state_q != GRANT0)) begin
      last_d = 1'b0;
    end else if ((state_d == GRANT1) && (state_q != GRANT1)) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end

    // The count only survives an unchanged grant with an unanswered strobe
    if (!WD_EN || (state_q == IDLE) || (state_d != state_q) || timeout_s) begin
      wd_d = '0;
    end else if (own_stb_s && !term_s) begin
      wd_d = wd_q + WD_ONE;
    end else begin
      wd_d = '0;
    end
  end

  // Arbiter state registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  // Bus steering from the current owner; a watchdog hit masks the slave and forces err
  always_comb begin
    s_addr_o  = '0;
    s_data_o  = '0;
    s_sel_o   = 4'h0;
    s_we_o    = 1'b0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    m0_data_o = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m0_rty_o  = 1'b0;
    m1_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    m1_rty_o  = 1'b0;
    case (state_q)
      GRANT0: begin
        s_addr_o  = m0_addr_i;
        s_data_o  = m0_data_i;
        s_sel_o   = m0_sel_i;
        s_we_o    = m0_we_i;
        s_cyc_o   = m0_cyc_i;
        s_stb_o   = m0_stb_i & ~timeout_s;
        m0_data_o = s_data_i;
        m0_ack_o  = s_ack_i & ~timeout_s;
        m0_err_o  = s_err_i | timeout_s;
        m0_rty_o  = s_rty_i & ~timeout_s;
      end
      GRANT1: begin
        s_addr_o  = m1_addr_i;
        s_data_o  = m1_data_i;
        s_sel_o   = m1_sel_i;
        s_we_o    = m1_we_i;
        s_cyc_o   = m1_cyc_i;
        s_stb_o   = m1_stb_i & ~timeout_s;
        m1_data_o = s_data_i;
        m1_ack_o  = s_ack_i & ~timeout_s;
        m1_err_o  = s_err_i | timeout_s;
        m1_rty_o  = s_rty_i & ~timeout_s;
      end
      default: begin
        s_cyc_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arbiter_2m_1s.sv
// Table-driven bench for arbiter_2m_1s: each row drives one cycle and its expected outputs go
// through a scoreboard queue; a second instance with the watchdog disabled is soaked by hand.
module tb_arbiter_2m_1s;

  localparam logic [31:0] M0_ADDR = 32'h0000_0100;
  localparam logic [31:0] M1_ADDR = 32'h0000_0200;
  localparam logic [31:0] M0_WDAT = 32'h1111_1111;
  localparam logic [31:0] M1_WDAT = 32'h2222_2222;
  localparam logic [3:0]  M0_SEL  = 4'hF;
  localparam logic [3:0]  M1_SEL  = 4'h3;

  // flag order: s_cyc s_stb m0_ack m0_err m0_rty m1_ack m1_err m1_rty
  localparam logic [7:0] F0 = 8'b0000_0000;
  localparam logic [7:0] CS = 8'b1100_0000;
  localparam logic [7:0] A0 = 8'b0010_0000;
  localparam logic [7:0] E0 = 8'b0001_0000;
  localparam logic [7:0] R0 = 8'b0000_1000;
  localparam logic [7:0] A1 = 8'b0000_0100;
  localparam logic [7:0] TO = 8'b1001_0000;

  typedef struct {
    logic        rst;
    logic        m0;
    logic        m1;
    logic        ack;
    logic        err;
    logic        rty;
    logic [31:0] sdata;
    logic [7:0]  flags;
    logic [1:0]  own;
  } vec_t;

  typedef struct {
    int          idx;
    logic [7:0]  flags;
    logic [1:0]  own;
    logic [31:0] sdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_addr, m0_wdat, m1_addr, m1_wdat, s_rdat;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic        s_ack, s_err, s_rty;

  logic [31:0] m0_rdat, m1_rdat, s_addr, s_wdat;
  logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;

  logic [31:0] z_m0_rdat, z_m1_rdat, z_s_addr, z_s_wdat;
  logic        z_m0_ack, z_m0_err, z_m0_rty, z_m1_ack, z_m1_err, z_m1_rty;
  logic        z_s_cyc, z_s_stb, z_s_we;
  logic [3:0]  z_s_sel;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  arbiter_2m_1s #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4), .TO_WIDTH(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_addr_i(m0_addr), .m0_data_i(m0_wdat), .m0_data_o(m0_rdat),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
    .m1_addr_i(m1_addr), .m1_data_i(m1_wdat), .m1_data_o(m1_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
    .s_addr_o(s_addr), .s_data_o(s_wdat), .s_data_i(s_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty)
  );

  arbiter_2m_1s #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(0), .TO_WIDTH(8)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_addr_i(m0_addr), .m0_data_i(m0_wdat), .m0_data_o(z_m0_rdat),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_ack_o(z_m0_ack), .m0_err_o(z_m0_err), .m0_rty_o(z_m0_rty),
    .m1_addr_i(m1_addr), .m1_data_i(m1_wdat), .m1_data_o(z_m1_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_ack_o(z_m1_ack), .m1_err_o(z_m1_err), .m1_rty_o(z_m1_rty),
    .s_addr_o(z_s_addr), .s_data_o(z_s_wdat), .s_data_i(s_rdat),
    .s_cyc_o(z_s_cyc), .s_stb_o(z_s_stb), .s_we_o(z_s_we), .s_sel_o(z_s_sel),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty)
  );

  function automatic vec_t v(input logic rst, input logic r0, input logic r1, input logic ack,
                             input logic err, input logic rty, input logic [31:0] sd,
                             input logic [7:0] fl, input logic [1:0] own);
    vec_t t;
    t.rst = rst; t.m0 = r0; t.m1 = r1; t.ack = ack; t.err = err; t.rty = rty;
    t.sdata = sd; t.flags = fl; t.own = own;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rst_n  = t.rst;
    m0_cyc = t.m0; m0_stb = t.m0;
    m1_cyc = t.m1; m1_stb = t.m1;
    s_ack  = t.ack; s_err = t.err; s_rty = t.rty;
    s_rdat = t.sdata;
  endtask

  task automatic check_front();
    exp_t e;
    logic [31:0] ea, ed, e0, e1;
    logic [3:0]  es;
    logic        ew;
    logic [7:0]  obs;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: queue empty, got 0 entries, required 1");
      return;
    end
    e  = sb.pop_front();
    ea = (e.own == 2'd1) ? M0_ADDR : (e.own == 2'd2) ? M1_ADDR : 32'h0;
    ed = (e.own == 2'd1) ? M0_WDAT : (e.own == 2'd2) ? M1_WDAT : 32'h0;
    es = (e.own == 2'd1) ? M0_SEL  : (e.own == 2'd2) ? M1_SEL  : 4'h0;
    ew = (e.own == 2'd2);
    e0 = (e.own == 2'd1) ? e.sdata : 32'h0;
    e1 = (e.own == 2'd2) ? e.sdata : 32'h0;
    obs = {s_cyc, s_stb, m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty};
    if (obs !== e.flags || s_addr !== ea || s_wdat !== ed || s_sel !== es || s_we !== ew ||
        m0_rdat !== e0 || m1_rdat !== e1) begin
      errors++;
      $display("FAIL vec%0d: got flags=%b addr=%h wdat=%h sel=%h we=%b m0d=%h m1d=%h, required flags=%b addr=%h wdat=%h sel=%h we=%b m0d=%h m1d=%h",
               e.idx, obs, s_addr, s_wdat, s_sel, s_we, m0_rdat, m1_rdat,
               e.flags, ea, ed, es, ew, e0, e1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m0_addr = M0_ADDR; m0_wdat = M0_WDAT; m0_sel = M0_SEL; m0_we = 1'b0;
    m1_addr = M1_ADDR; m1_wdat = M1_WDAT; m1_sel = M1_SEL; m1_we = 1'b1;
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_rdat = 32'h0;

    // reset and single m0 read
    vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5555_0000, CS, 2'd1));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, CS | A0, 2'd1));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd1));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));
    // simultaneous requests after reset, handover and alternation
    vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));
    vecs.push_back(v(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));
    vecs.push_back(v(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA0A0_A0A0, CS | A0, 2'd1));
    vecs.push_back(v(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd1));
    vecs.push_back(v(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hB1B1_B1B1, CS | A1, 2'd2));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd2));
    vecs.push_back(v(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));
    vecs.push_back(v(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0C01, CS | A0, 2'd1));
    vecs.push_back(v(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd1));
    vecs.push_back(v(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0C02, CS | A1, 2'd2));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd2));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0C03, CS | A0, 2'd1));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd1));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));
    // m1 burst holds the grant against a waiting m0
    vecs.push_back(v(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(v(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hC000_0000 + 32'(i), CS | A1, 2'd2));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd2));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hC0C0_0005, CS | A0, 2'd1));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd1));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));
    // err in IDLE dropped, err/rty passthrough
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, F0, 2'd0));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, CS | E0, 2'd1));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, CS | R0, 2'd1));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd1));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));
    // reset in GRANT1 mid-strobe, then m0 wins the tie
    vecs.push_back(v(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));
    vecs.push_back(v(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, CS, 2'd2));
    vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));
    vecs.push_back(v(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));
    vecs.push_back(v(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hE4E4_E4E4, CS | A0, 2'd1));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd1));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));
    // watchdog with TIMEOUT=4: err in 5th and 10th unanswered strobe cycle
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, CS, 2'd1));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, TO, 2'd1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, CS, 2'd1));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, TO, 2'd1));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00AA, CS | A0, 2'd1));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd1));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      @(posedge clk);
      #1;
      drive(vecs[i]);
      e.idx = i; e.flags = vecs[i].flags; e.own = vecs[i].own; e.sdata = vecs[i].sdata;
      sb.push_back(e);
      @(negedge clk);
      check_front();
    end

    // watchdog disabled: 1000 unanswered strobe cycles never produce err
    @(posedge clk);
    #1;
    drive(v(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));
    @(negedge clk);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      checks++;
      if (z_m0_err !== 1'b0 || z_s_stb !== 1'b1 || z_s_cyc !== 1'b1) begin
        errors++;
        $display("FAIL no_watchdog cycle %0d: got err=%b stb=%b cyc=%b, required err=0 stb=1 cyc=1",
                 c, z_m0_err, z_s_stb, z_s_cyc);
      end
    end
    @(posedge clk);
    #1;
    drive(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F0, 2'd0));
    repeat (2) @(negedge clk);
    checks++;
    if (z_s_cyc !== 1'b0 || z_m0_err !== 1'b0) begin
      errors++;
      $display("FAIL no_watchdog release: got cyc=%b err=%b, required cyc=0 err=0", z_s_cyc, z_m0_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
